// File: rtl/trig_capture_buf.sv
// Triggered capture buffer: records samples into a circular RAM around a trigger event and
// replays the frozen record oldest-first through a request/valid readout port.
module trig_capture_buf #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned AUTO_TO = 65535
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              samp_en,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [1:0]        trig_mode,
  input  logic [ADDR_W-1:0] pre_trig,
  input  logic              rd_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              trig_forced,
  output logic [ADDR_W-1:0] trig_addr
);

  localparam int unsigned ToW = (AUTO_TO > 0) ? $clog2(AUTO_TO + 1) : 1;
  localparam logic [ToW-1:0]    ToLast   = ToW'((AUTO_TO > 0) ? AUTO_TO - 1 : 0);
  localparam logic [ToW-1:0]    ToOne    = 1;
  localparam logic [ADDR_W:0]   DepthCnt = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CntOne   = 1;
  localparam logic [ADDR_W-1:0] AddrOne  = 1;

  typedef enum logic [2:0] {
    StIdle,
    StPreFill,
    StWaitTrig,
    StPostFill,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     rd_cnt_q, rd_cnt_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [ADDR_W:0]     post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0]   pre_q, pre_d;
  logic [ToW-1:0]      to_cnt_q, to_cnt_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic                prev_valid_q, prev_valid_d;
  logic [DATA_W-1:0]   level_q, level_d;
  logic [1:0]          mode_q, mode_d;
  logic                forced_q, forced_d;
  logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q;
  logic                we, re, start;
  logic                rise, fall, real_hit, time_out;

  logic [DATA_W-1:0] mem [DEPTH];

  always_comb begin
    rise     = prev_valid_q && (prev_q < level_q) && (din >= level_q);
    fall     = prev_valid_q && (prev_q >= level_q) && (din < level_q);
    real_hit = 1'b0;
    case (mode_q)
      2'b00:   real_hit = rise;
      2'b01:   real_hit = fall;
      2'b10:   real_hit = rise | fall;
      default: real_hit = 1'b1;
    endcase
    time_out = (AUTO_TO != 0) && (to_cnt_q == ToLast);
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rd_cnt_d     = rd_cnt_q;
    cnt_d        = cnt_q;
    post_cnt_d   = post_cnt_q;
    pre_d        = pre_q;
    to_cnt_d     = to_cnt_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    level_d      = level_q;
    mode_d       = mode_q;
    forced_d     = forced_q;
    trig_addr_d  = trig_addr_q;
    rd_valid_d   = 1'b0;
    we           = 1'b0;
    re           = 1'b0;
    start        = 1'b0;

    unique case (state_q)
      StIdle: begin
        start = arm;
      end
      StPreFill: begin
        if (samp_en) begin
          we           = 1'b1;
          wr_ptr_d     = wr_ptr_q + AddrOne;
          prev_d       = din;
          prev_valid_d = 1'b1;
          cnt_d        = cnt_q + CntOne;
          if (cnt_q + CntOne == {1'b0, pre_q}) begin
            state_d = StWaitTrig;
          end
        end
      end
      StWaitTrig: begin
        if (samp_en) begin
          we           = 1'b1;
          wr_ptr_d     = wr_ptr_q + AddrOne;
          prev_d       = din;
          prev_valid_d = 1'b1;
          to_cnt_d     = to_cnt_q + ToOne;
          if (real_hit || time_out) begin
            trig_addr_d = wr_ptr_q;
            forced_d    = ~real_hit;
            cnt_d       = CntOne;
            if (post_cnt_q == CntOne) begin
              state_d  = StDone;
              rd_ptr_d = wr_ptr_q + AddrOne;
              rd_cnt_d = '0;
            end else begin
              state_d = StPostFill;
            end
          end
        end
      end
      StPostFill: begin
        if (samp_en) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + AddrOne;
          cnt_d    = cnt_q + CntOne;
          if (cnt_q + CntOne == post_cnt_q) begin
            state_d  = StDone;
            rd_ptr_d = wr_ptr_q + AddrOne;
            rd_cnt_d = '0;
          end
        end
      end
      StDone: begin
        // The last rd_valid goes out while still in StDone; leave on the following cycle.
        if (arm) begin
          start = 1'b1;
        end else if (rd_cnt_q == DepthCnt) begin
          state_d = StIdle;
        end else if (rd_req) begin
          re         = 1'b1;
          rd_valid_d = 1'b1;
          rd_ptr_d   = rd_ptr_q + AddrOne;
          rd_cnt_d   = rd_cnt_q + CntOne;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      // pre_trig is ADDR_W wide, so it can never exceed DEPTH-1.
      state_d      = (pre_trig == '0) ? StWaitTrig : StPreFill;
      wr_ptr_d     = '0;
      prev_valid_d = 1'b0;
      forced_d     = 1'b0;
      mode_d       = trig_mode;
      level_d      = trig_level;
      pre_d        = pre_trig;
      post_cnt_d   = DepthCnt - {1'b0, pre_trig};
      cnt_d        = '0;
      to_cnt_d     = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rd_cnt_q     <= '0;
      cnt_q        <= '0;
      post_cnt_q   <= '0;
      pre_q        <= '0;
      to_cnt_q     <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      level_q      <= '0;
      mode_q       <= '0;
      forced_q     <= 1'b0;
      trig_addr_q  <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_cnt_q     <= rd_cnt_d;
      cnt_q        <= cnt_d;
      post_cnt_q   <= post_cnt_d;
      pre_q        <= pre_d;
      to_cnt_q     <= to_cnt_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      level_q      <= level_d;
      mode_q       <= mode_d;
      forced_q     <= forced_d;
      trig_addr_q  <= trig_addr_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (we) begin
      mem[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (re) begin
      rd_data_q <= mem[rd_ptr_q];
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign busy        = (state_q == StPreFill) || (state_q == StWaitTrig) || (state_q == StPostFill);
  assign done        = (state_q == StDone);
  assign trig_forced = forced_q;
  assign trig_addr   = trig_addr_q;

endmodule
